x7seg_scan_rx: RTL and testbench
================================

X7SEG_SCAN_RX -- requirements
Module: x7seg_scan_rx

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive cycles a sampled pattern must hold before capture (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the cycles without any capture before partial frame state is discarded.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port a_to_g, input, 7 bits: active-low segments {a,b,c,d,e,f,g}, with a on bit 6.
REQ-006 The block SHALL have port an, input, 4 bits: active-low digit enables, an[0] for the rightmost digit.
REQ-007 The block SHALL have port digits, output, 16 bits: the last complete frame, with an[0] in digits[3:0] and an[3] in digits[15:12].
REQ-008 The block SHALL have port frame_valid, output, 1 bit: a one-cycle pulse when digits updates.
REQ-009 The block SHALL have port seg_err, output, 1 bit: a one-cycle pulse when an unrecognised segment pattern or a non-one-hot an is captured.
REQ-010 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when partial frame state is discarded.

Function
REQ-011 a_to_g and an SHALL pass through a 2-flop synchroniser before any use.
REQ-012 The FSM SHALL have states IDLE, SETTLE and HOLD.
- IDLE: synced an equals 4'b1111 (blank).
- SETTLE: a new non-blank {an,a_to_g} pattern is counting stability.
- HOLD: the pattern has been captured and is waiting for change.
REQ-013 Any change of synced {an,a_to_g} SHALL restart the stability counter at 1 and enter SETTLE, or enter IDLE if the new an equals 1111.
REQ-014 When the pattern has held for STABLE_CYCLES consecutive cycles in SETTLE, the block SHALL capture it on the next edge and move to HOLD.
- A HOLD pattern SHALL never be captured twice.
REQ-015 Decode SHALL use this table (hex value : pattern):
- 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
- 8:00, 9:04, A:08, b:60, C:31, d:42, E:30, F:38
- Any other pattern SHALL be invalid.
REQ-016 A capture with a one-hot-low an and a valid pattern SHALL write the nibble into shadow slot k and set seen[k].
- A repeated slot SHALL overwrite the stored nibble.
REQ-017 A capture with an invalid pattern or a non-one-hot an SHALL pulse seg_err the cycle after capture.
- Such a capture SHALL leave the shadow and seen unchanged.
REQ-018 When seen becomes 4'b1111, the block SHALL load digits from the shadow and clear seen on the next edge.
- frame_valid SHALL be high in the cycle digits first shows the new value.
REQ-019 Capture-to-frame_valid latency SHALL be exactly 1 cycle after the completing capture.
REQ-020 The idle counter SHALL reset on every valid capture and saturate at TIMEOUT_CYCLES.
- On reaching TIMEOUT_CYCLES with seen nonzero, the block SHALL clear seen and pulse timeout once.
- digits SHALL be retained on timeout.
REQ-021 A timeout and a completing capture in the same cycle SHALL be resolved in favour of the capture: frame_valid pulses and timeout does not.
REQ-022 Counter widths SHALL be derived with $clog2 of the parameters, and the counters SHALL NOT wrap.

Reset
REQ-023 While clr is high, the synchronisers, shadow, seen and counters SHALL be zero, and the FSM SHALL be in IDLE.
REQ-024 While clr is high, digits SHALL be 16'h0000 and frame_valid, seg_err and timeout SHALL be 0.
REQ-025 Assertion of clr mid-frame SHALL discard the partial frame.
- After deassertion, capture SHALL require four fresh captures covering all digits.

Structure
REQ-026 Package x7seg_pkg SHALL hold the FSM state enum and the 16-entry segment-code constant table.
- x7seg_pkg SHALL be shared with the display driver.
REQ-027 A combinational sub-module x7seg_decode (7-bit pattern in; 4-bit value and valid out) SHALL implement the decode table.

Verification
REQ-028 The bench SHALL scan digits 1,2,3,4 on an 0111/1011/1101/1110 with 8 cycles per digit.
- Required response: frame_valid pulses and digits is 16'h1234 with seg_err = 0.
REQ-029 The bench SHALL hold each digit for only STABLE_CYCLES-1 cycles.
- Required response: no capture and no frame_valid.
REQ-030 The bench SHALL drive a_to_g 7'h7F on an 1110 for 8 cycles.
- Required response: one seg_err pulse, and seen is unchanged.
REQ-031 The bench SHALL drive an 1100 with a valid pattern.
- Required response: one seg_err pulse and no slot written.
REQ-032 The bench SHALL capture three digits and then blank the display (an 1111) for TIMEOUT_CYCLES (bench parameter 50).
- Required response: one timeout pulse, and digits keeps its previous value.
REQ-033 The bench SHALL assert clr after two captures and then scan 5,6,7,8.
- Required response: digits reads 16'h0000 during reset, then 16'h5678 after the next complete scan.

Source files
------------

// File: rtl/x7seg_pkg.sv
// Shared definitions for the seven-segment scan receiver and the display driver:
// receiver FSM states, segment code table and small helpers.
package x7seg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_t;

    // Active-low {a,b,c,d,e,f,g} pattern for each hex value, a on bit 6.
    localparam logic [6:0] SegCodes [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/x7seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder; any pattern not in the
// code table is reported invalid.
module x7seg_decode
    import x7seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SegCodes[i]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x7seg_scan_rx.sv
// Receives a multiplexed 4-digit seven-segment scan, debounces each digit pattern,
// and assembles complete frames of four hex nibbles.
module x7seg_scan_rx
    import x7seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        timeout
);

    localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [IdleW-1:0] IdleOne  = IdleW'(1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_CYCLES);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

    logic [10:0]      sync1_q, pat_s, prev_q;
    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [15:0]      shadow_q, shadow_d, digits_q, digits_d;
    logic [3:0]       seen_q, seen_d, slot_sel;
    logic             fv_q, fv_d, se_q, se_d, to_q, to_d;
    logic             capture, good;
    logic [3:0]       dec_value;
    logic             dec_valid;

    x7seg_decode u_decode (
        .pattern (pat_s[6:0]),
        .value   (dec_value),
        .valid   (dec_valid)
    );

    assign slot_sel = ~pat_s[10:7];
    assign good     = capture && dec_valid && is_onehot4(slot_sel);

    // Counter holds how many cycles the current pattern has been seen, minus the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (pat_s != prev_q) begin
            if (pat_s[10:7] == 4'b1111) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                state_d = StSettle;
                cnt_d   = CntOne;
            end
        end else if (state_q == StSettle) begin
            if (cnt_q >= CntLast) begin
                capture = 1'b1;
                state_d = StHold;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        digits_d = digits_q;
        idle_d   = idle_q;
        fv_d     = 1'b0;
        se_d     = capture && !good;
        to_d     = 1'b0;
        if (good) begin
            idle_d = '0;
        end else if (idle_q != IdleMax) begin
            idle_d = idle_q + IdleOne;
        end
        if (seen_q == 4'hF) begin
            digits_d = shadow_q;
            fv_d     = 1'b1;
            seen_d   = '0;
        end
        if (good) begin
            for (int k = 0; k < 4; k++) begin
                if (slot_sel[k]) shadow_d[k*4 +: 4] = dec_value;
            end
            seen_d = seen_d | slot_sel;
        end else if (seen_q != 4'h0 && seen_q != 4'hF && idle_q == IdleLast) begin
            // A completing capture takes priority over an expiring idle count.
            seen_d = '0;
            to_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q  <= '0;
            pat_s    <= '0;
            prev_q   <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            idle_q   <= '0;
            shadow_q <= '0;
            seen_q   <= '0;
            digits_q <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            sync1_q  <= {an, a_to_g};
            pat_s    <= sync1_q;
            prev_q   <= pat_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
            to_q     <= to_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = fv_q;
    assign seg_err     = se_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_x7seg_scan_rx.sv
// Bench for x7seg_scan_rx: directed scan scenarios plus randomized runs, checked
// against a run-length level model of capture, frame assembly and timeout.
module tb_x7seg_scan_rx;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 50;
    localparam int FLUSH   = TIMEOUT + 20;

    logic        clk = 1'b0;
    logic        clr;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic [15:0] digits;
    logic        frame_valid, seg_err, timeout;

    x7seg_scan_rx #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .a_to_g      (a_to_g),
        .an          (an),
        .digits      (digits),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed pulse counts and frame values, written only by the monitor.
    int          obs_fv = 0, obs_se = 0, obs_to = 0;
    logic [15:0] obs_frames [$];

    always @(negedge clk) begin
        if (!clr) begin
            if (frame_valid) begin
                obs_fv++;
                obs_frames.push_back(digits);
            end
            if (seg_err) obs_se++;
            if (timeout) obs_to++;
        end
    end

    logic [6:0] codes [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // Reference model state: runs of identical synced patterns, in input-cycle time.
    logic [10:0] m_cur;
    int          m_len, m_start, m_t, m_last;
    bit          m_capt;
    logic [15:0] m_shadow, m_digits;
    logic [3:0]  m_seen;
    int          m_fv, m_se, m_to;
    logic [15:0] exp_frames [$];
    int          base_fv, base_se, base_to, base_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int decode_ref(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur    = '0;
        m_len    = 0;
        m_capt   = 1'b1;
        m_shadow = '0;
        m_seen   = '0;
        m_digits = '0;
    endtask

    task automatic model_capture(input logic [3:0] a, input logic [6:0] s, input int t);
        int v;
        int zeros;
        int k;
        v     = decode_ref(s);
        zeros = 0;
        k     = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                zeros++;
                k = i;
            end
        end
        if (zeros == 1 && v >= 0) begin
            if (m_seen != 0 && t > m_last + TIMEOUT) begin
                m_to++;
                m_seen = '0;
            end
            m_shadow[k*4 +: 4] = 4'(v);
            m_seen[k]          = 1'b1;
            m_last             = t;
            if (m_seen == 4'hF) begin
                m_digits = m_shadow;
                exp_frames.push_back(m_shadow);
                m_fv++;
                m_seen = '0;
            end
        end else begin
            m_se++;
        end
    endtask

    task automatic model_run(input logic [3:0] a, input logic [6:0] s, input int len);
        if ({a, s} != m_cur) begin
            m_cur   = {a, s};
            m_len   = 0;
            m_capt  = 1'b0;
            m_start = m_t;
        end
        m_len += len;
        if (a != 4'hF && !m_capt && m_len >= STABLE) begin
            m_capt = 1'b1;
            model_capture(a, s, m_start + STABLE - 1);
        end
        m_t += len;
    endtask

    // Called just after a rising edge; holds the pattern for len cycles.
    task automatic drive_run(input logic [3:0] a, input logic [6:0] s, input int len);
        model_run(a, s, len);
        an     = a;
        a_to_g = s;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_scn();
        base_fv  = obs_fv;
        base_se  = obs_se;
        base_to  = obs_to;
        base_idx = obs_frames.size();
        m_fv     = 0;
        m_se     = 0;
        m_to     = 0;
        exp_frames.delete();
    endtask

    // Long blank lets every pending pulse land and times out any partial frame.
    task automatic end_scn(input string tag);
        int n;
        drive_run(4'hF, 7'h7F, FLUSH);
        if (m_seen != 0) begin
            m_to++;
            m_seen = '0;
        end
        check_eq({tag, "/frame_valid_count"}, 32'(obs_fv - base_fv), 32'(m_fv));
        check_eq({tag, "/seg_err_count"}, 32'(obs_se - base_se), 32'(m_se));
        check_eq({tag, "/timeout_count"}, 32'(obs_to - base_to), 32'(m_to));
        check_eq({tag, "/digits"}, 32'(digits), 32'(m_digits));
        n = obs_frames.size() - base_idx;
        if (exp_frames.size() < n) n = exp_frames.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "/frame_value"}, 32'(obs_frames[base_idx + i]), 32'(exp_frames[i]));
        end
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "/rst_digits"}, 32'(digits), 32'h0);
        check_eq({tag, "/rst_flags"}, {29'd0, frame_valid, seg_err, timeout}, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        clr    = 1'b1;
        an     = 4'hF;
        a_to_g = 7'h7F;
        #2;
        reset_checks({tag, "_early"});
        repeat (3) @(posedge clk);
        #1;
        reset_checks({tag, "_late"});
        model_reset();
        m_t += 3;
        clr = 1'b0;
    endtask

    task automatic scan4(input logic [15:0] val, input int len);
        for (int k = 3; k >= 0; k--) begin
            drive_run(~(4'b0001 << k), codes[val[k*4 +: 4]], len);
        end
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int         r;

        m_t    = 0;
        m_last = 0;
        model_reset();
        clr    = 1'b1;
        an     = 4'hF;
        a_to_g = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        clr = 1'b0;
        m_t += 3;

        begin_scn();
        scan4(16'h1234, 8);
        end_scn("scan_1234");
        check_eq("scan_1234/digits_const", 32'(digits), 32'h1234);

        begin_scn();
        scan4(16'h5678, STABLE - 1);
        end_scn("short_hold");

        begin_scn();
        drive_run(4'b0111, codes[9], 8);
        drive_run(4'b1011, codes[10], 8);
        drive_run(4'b1101, codes[11], 8);
        drive_run(4'b1110, 7'h7F, 8);
        drive_run(4'b1110, codes[12], 8);
        end_scn("bad_pattern");

        begin_scn();
        drive_run(4'b0111, codes[13], 8);
        drive_run(4'b1011, codes[14], 8);
        drive_run(4'b1101, codes[15], 8);
        drive_run(4'b1100, codes[5], 8);
        drive_run(4'b1110, codes[0], 8);
        end_scn("bad_an");

        begin_scn();
        drive_run(4'b0111, codes[1], 8);
        drive_run(4'b1011, codes[2], 8);
        drive_run(4'b1101, codes[3], 8);
        drive_run(4'hF, 7'h7F, TIMEOUT);
        end_scn("timeout");

        begin_scn();
        drive_run(4'b0111, codes[9], 8);
        drive_run(4'b1011, codes[10], 8);
        do_reset("mid_frame");
        drive_run(4'b1101, codes[7], 8);
        drive_run(4'b1110, codes[8], 8);
        drive_run(4'b0111, codes[5], 8);
        drive_run(4'b1011, codes[6], 8);
        end_scn("reset_rescan");
        check_eq("reset_rescan/digits_const", 32'(digits), 32'h5678);

        for (int it = 0; it < 20; it++) begin
            begin_scn();
            for (int j = 0; j < 8; j++) begin
                r = $urandom_range(0, 9);
                if (r < 7) ra = ~(4'b0001 << $urandom_range(0, 3));
                else if (r == 7) ra = 4'hF;
                else ra = 4'($urandom);
                if ($urandom_range(0, 3) != 0) rs = codes[$urandom_range(0, 15)];
                else rs = 7'($urandom);
                drive_run(ra, rs, $urandom_range(2, 6));
            end
            end_scn($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
